// File: rtl/led_sequencer.sv
// LED colour sequencer: synchronises and debounces a raw push button, then
// steps a colour code through [MIN_CODE..MAX_CODE] in one of four modes
// (continuous, single-step, freeze, ping-pong). It emits a one-cycle wrap
// pulse whenever the code wraps or reverses at a limit.
//
// Handshake: none. Every output is a plain registered level. btn_db and
// colour change only on a rising clk edge. wrap is high for exactly the one
// cycle that follows the edge on which colour wrapped or reversed.
module led_sequencer #(
  parameter int WIDTH    = 3,
  parameter int MIN_CODE = 1,
  parameter int MAX_CODE = 6,
  parameter int DEBOUNCE = 4,
  parameter int STEP_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] colour,
  output logic             wrap,
  output logic             btn_db
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [DW-1:0]    DB_LAST  = DW'(DEBOUNCE - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(STEP_DIV - 1);
  localparam logic [WIDTH-1:0] MIN_C    = WIDTH'(MIN_CODE);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_CODE);

  localparam logic [1:0] MODE_CONT   = 2'b00;
  localparam logic [1:0] MODE_SINGLE = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;
  localparam logic [1:0] MODE_PP     = 2'b11;

  logic             sync1_q, sync2_q;
  logic [DW-1:0]    db_cnt_q, db_cnt_d;
  logic             btn_db_q, btn_db_d;
  logic             btn_db_prev_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic [1:0]       mode_q;
  logic             pp_down_q, pp_down_d;
  logic [WIDTH-1:0] colour_q, colour_d;
  logic             wrap_q, wrap_d;
  logic             step;
  logic             mode_chg;

  // Debounce: btn_db follows the synchronised button only after it has
  // disagreed with btn_db for DEBOUNCE consecutive cycles.
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Step strobe and prescaler. The current mode input takes effect
  // immediately. A mode change also restarts the prescaler.
  always_comb begin
    step     = 1'b0;
    pre_d    = '0;
    mode_chg = (mode != mode_q);
    case (mode)
      MODE_CONT, MODE_PP: begin
        if (btn_db_q) begin
          if (pre_q == PRE_LAST) begin
            step = 1'b1;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      MODE_SINGLE: step = btn_db_q & ~btn_db_prev_q;
      MODE_FREEZE: step = 1'b0;
      default:     step = 1'b0;
    endcase
    if (mode_chg) begin
      pre_d = '0;
    end
  end

  // Colour arithmetic applied on a step. The order of checks matters:
  // out-of-range recovery first, then the degenerate single-code range,
  // then ping-pong reversal, then plain wrap-around counting.
  always_comb begin
    colour_d  = colour_q;
    wrap_d    = 1'b0;
    pp_down_d = pp_down_q;
    if (step) begin
      if ((colour_q < MIN_C) || (colour_q > MAX_C)) begin
        colour_d = MIN_C;
      end else if (MIN_C == MAX_C) begin
        wrap_d = 1'b1;
      end else if (mode == MODE_PP) begin
        if (!pp_down_q) begin
          if (colour_q == MAX_C) begin
            colour_d  = MAX_C - 1'b1;
            pp_down_d = 1'b1;
            wrap_d    = 1'b1;
          end else begin
            colour_d = colour_q + 1'b1;
          end
        end else begin
          if (colour_q == MIN_C) begin
            colour_d  = MIN_C + 1'b1;
            pp_down_d = 1'b0;
            wrap_d    = 1'b1;
          end else begin
            colour_d = colour_q - 1'b1;
          end
        end
      end else if (!dir) begin
        if (colour_q == MAX_C) begin
          colour_d = MIN_C;
          wrap_d   = 1'b1;
        end else begin
          colour_d = colour_q + 1'b1;
        end
      end else begin
        if (colour_q == MIN_C) begin
          colour_d = MAX_C;
          wrap_d   = 1'b1;
        end else begin
          colour_d = colour_q - 1'b1;
        end
      end
    end
  end

  // State registers. The synchronous reset overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_cnt_q      <= '0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      pre_q         <= '0;
      mode_q        <= MODE_CONT;
      pp_down_q     <= 1'b0;
      colour_q      <= MIN_C;
      wrap_q        <= 1'b0;
    end else begin
      sync1_q       <= button;
      sync2_q       <= sync1_q;
      db_cnt_q      <= db_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      pre_q         <= pre_d;
      mode_q        <= mode;
      pp_down_q     <= pp_down_d;
      colour_q      <= colour_d;
      wrap_q        <= wrap_d;
    end
  end

  assign colour = colour_q;
  assign wrap   = wrap_q;
  assign btn_db = btn_db_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with default parameters. Each table row
// holds its inputs for n cycles and gives the outputs expected after every
// one of those edges.
module tb_led_sequencer;

  logic       clk;
  logic       rst;
  logic       button;
  logic       dir;
  logic [1:0] mode;
  logic [2:0] colour;
  logic       wrap;
  logic       btn_db;

  int checks = 0;
  int errors = 0;

  led_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .dir    (dir),
    .mode   (mode),
    .colour (colour),
    .wrap   (wrap),
    .btn_db (btn_db)
  );

  // Clock and power-on values
  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    button = 1'b0;
    dir    = 1'b0;
    mode   = 2'b00;
  end
  always #5 clk = ~clk;

  // Hard stop in case the run hangs
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic       button;
    logic       dir;
    logic [1:0] mode;
    int         n;
    logic [2:0] colour;
    logic       wrap;
    logic       db;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic b, input logic d,
                              input logic [1:0] m, input int n,
                              input logic [2:0] c, input logic w, input logic db);
    vec_t v;
    v.rst = r; v.button = b; v.dir = d; v.mode = m; v.n = n;
    v.colour = c; v.wrap = w; v.db = db;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Stimulus and checking
  initial begin
    int lat;

    // 1: reset for two cycles, then idle with the button low
    add(1, 0, 0, 2'b00, 2, 1, 0, 0);
    add(0, 0, 0, 2'b00, 3, 1, 0, 0);
    // 2: a 3-cycle glitch never reaches btn_db
    add(0, 1, 0, 2'b00, 3, 1, 0, 0);
    add(0, 0, 0, 2'b00, 5, 1, 0, 0);
    // 3: continuous up; held for 30 cycles, then released
    add(0, 1, 0, 2'b00, 5, 1, 0, 0);
    add(0, 1, 0, 2'b00, 2, 1, 0, 1);
    for (int c = 2; c <= 6; c++) add(0, 1, 0, 2'b00, 2, 3'(c), 0, 1);
    add(0, 1, 0, 2'b00, 1, 1, 1, 1);
    add(0, 1, 0, 2'b00, 1, 1, 0, 1);
    for (int c = 2; c <= 6; c++) add(0, 1, 0, 2'b00, 2, 3'(c), 0, 1);
    add(0, 1, 0, 2'b00, 1, 1, 1, 1);
    add(0, 0, 0, 2'b00, 1, 1, 0, 1);
    add(0, 0, 0, 2'b00, 2, 2, 0, 1);
    add(0, 0, 0, 2'b00, 2, 3, 0, 1);
    add(0, 0, 0, 2'b00, 1, 4, 0, 0);
    add(0, 0, 0, 2'b00, 4, 4, 0, 0);
    // 4: single-step, three 10-cycle presses separated by 10 low cycles
    add(1, 0, 0, 2'b01, 1, 1, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      add(0, 1, 0, 2'b01, 5, 3'(c), 0, 0);
      add(0, 1, 0, 2'b01, 1, 3'(c), 0, 1);
      add(0, 1, 0, 2'b01, 4, 3'(c + 1), 0, 1);
      add(0, 0, 0, 2'b01, 5, 3'(c + 1), 0, 1);
      add(0, 0, 0, 2'b01, 5, 3'(c + 1), 0, 0);
    end
    // 5: ping-pong, 1..6, 5..1, 2.. with wrap at both reversals
    add(1, 0, 0, 2'b11, 1, 1, 0, 0);
    add(0, 1, 0, 2'b11, 5, 1, 0, 0);
    add(0, 1, 0, 2'b11, 2, 1, 0, 1);
    for (int c = 2; c <= 6; c++) add(0, 1, 0, 2'b11, 2, 3'(c), 0, 1);
    add(0, 1, 0, 2'b11, 1, 5, 1, 1);
    add(0, 1, 0, 2'b11, 1, 5, 0, 1);
    for (int c = 4; c >= 1; c--) add(0, 1, 0, 2'b11, 2, 3'(c), 0, 1);
    add(0, 1, 0, 2'b11, 1, 2, 1, 1);
    add(0, 1, 0, 2'b11, 1, 2, 0, 1);
    add(0, 1, 0, 2'b11, 1, 3, 0, 1);
    add(0, 0, 0, 2'b11, 1, 3, 0, 1);
    add(0, 0, 0, 2'b11, 2, 4, 0, 1);
    add(0, 0, 0, 2'b11, 2, 5, 0, 1);
    add(0, 0, 0, 2'b11, 1, 6, 0, 0);
    add(0, 0, 0, 2'b11, 4, 6, 0, 0);
    // 6: continuous down, reset while held, re-debounce, then freeze
    add(1, 0, 1, 2'b00, 1, 1, 0, 0);
    add(0, 1, 1, 2'b00, 5, 1, 0, 0);
    add(0, 1, 1, 2'b00, 2, 1, 0, 1);
    add(0, 1, 1, 2'b00, 1, 6, 1, 1);
    add(0, 1, 1, 2'b00, 1, 6, 0, 1);
    add(0, 1, 1, 2'b00, 2, 5, 0, 1);
    add(0, 1, 1, 2'b00, 1, 4, 0, 1);
    add(1, 1, 1, 2'b00, 1, 1, 0, 0);
    add(0, 1, 1, 2'b00, 5, 1, 0, 0);
    add(0, 1, 1, 2'b00, 2, 1, 0, 1);
    add(0, 1, 1, 2'b00, 1, 6, 1, 1);
    add(0, 1, 1, 2'b00, 1, 6, 0, 1);
    add(0, 1, 1, 2'b00, 1, 5, 0, 1);
    add(0, 1, 1, 2'b10, 8, 5, 0, 1);
    add(0, 0, 1, 2'b10, 5, 5, 0, 1);
    add(0, 0, 1, 2'b10, 5, 5, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        rst    = vecs[i].rst;
        button = vecs[i].button;
        dir    = vecs[i].dir;
        mode   = vecs[i].mode;
        @(posedge clk);
        #1;
        check($sformatf("vec%0d.%0d colour", i, j), 8'(colour), 8'(vecs[i].colour));
        check($sformatf("vec%0d.%0d wrap", i, j),   8'(wrap),   8'(vecs[i].wrap));
        check($sformatf("vec%0d.%0d btn_db", i, j), 8'(btn_db), 8'(vecs[i].db));
      end
    end

    // Latency: btn_db rises on the 6th edge counting the first sampling
    // edge, and the first continuous step follows STEP_DIV edges later.
    rst = 1'b1; button = 1'b0; dir = 1'b0; mode = 2'b00;
    @(posedge clk); #1;
    check("seq reset colour", 8'(colour), 8'd1);
    rst = 1'b0; button = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!btn_db && lat < 20);
    check("seq db latency", 8'(lat), 8'd6);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (colour == 3'd1 && lat < 20);
    check("seq first step latency", 8'(lat), 8'd2);
    check("seq first step colour", 8'(colour), 8'd2);
    button = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("seq released btn_db", 8'(btn_db), 8'd0);
    check("seq released wrap", 8'(wrap), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
